// File: rtl/peltier_regulator_pkg.sv
// Shared types and constants for the Peltier closed-loop regulator.
// State encodings, MCP3008 result-word field positions and the duty clamp.
package peltier_regulator_pkg;

    localparam int MCP_CH_MSB = 12;
    localparam int MCP_CH_LSB = 10;

    typedef enum logic [2:0] {
        REG_STATE_IDLE        = 3'd0,
        REG_STATE_WAIT_PERIOD = 3'd1,
        REG_STATE_REQUEST     = 3'd2,
        REG_STATE_WAIT_DATA   = 3'd3,
        REG_STATE_COMPUTE     = 3'd4,
        REG_STATE_APPLY       = 3'd5
    } reg_state_e;

    // Observation port: FSM state and the raw integrator bits.
    typedef struct packed {
        reg_state_e  state;
        logic [15:0] integ;
    } reg_dbg_t;

    function automatic logic [7:0] clamp_duty(input logic signed [17:0] u);
        if (u < 18'sd0) begin
            return 8'd0;
        end else if (u > 18'sd255) begin
            return 8'd255;
        end else begin
            return u[7:0];
        end
    endfunction

endpackage

// File: rtl/peltier_regulator_if.sv
// Snoop/request link between the MCP3008 interface and the regulator.
// mcp_valid marks the one cycle a result word is transferred (avail & accept); no back-pressure exists.
interface peltier_regulator_if;

    logic        mcp_busy;
    logic [15:0] mcp_data;
    logic        mcp_valid;
    logic        sample_req;

    modport master (
        output mcp_busy,
        output mcp_data,
        output mcp_valid,
        input  sample_req
    );

    modport slave (
        input  mcp_busy,
        input  mcp_data,
        input  mcp_valid,
        output sample_req
    );

endinterface

// File: rtl/peltier_regulator.sv
// Periodic MCP3008 sampling plus a shift-only PI law driving the Peltier duty cycle.
// All outputs are registered; dbg exposes the FSM state and integrator.
module peltier_regulator
    import peltier_regulator_pkg::*;
#(
    parameter logic [2:0]         CHANNEL  = 3'd0,
    parameter logic [23:0]        PERIOD   = 24'd1_000_000,
    parameter logic [15:0]        TIMEOUT  = 16'd50_000,
    parameter int                 KP_SHIFT = 2,
    parameter int                 KI_SHIFT = 4,
    parameter logic signed [15:0] INT_LIM  = 16'sd4000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [9:0]                setpoint,
    peltier_regulator_if.slave        mcp,
    output logic [7:0]                duty,
    output logic [9:0]                reading,
    output logic                      fault,
    output reg_dbg_t                  dbg
);

    localparam logic signed [16:0] LIM_POS = $signed({INT_LIM[15], INT_LIM});
    localparam logic signed [16:0] LIM_NEG = -LIM_POS;

    reg_state_e         state_q;
    logic [23:0]        period_cnt_q;
    logic [15:0]        to_cnt_q;
    logic [7:0]         duty_q;
    logic [9:0]         reading_q;
    logic               fault_q;
    logic               sample_req_q;
    logic signed [15:0] integ_q;
    logic signed [10:0] e_q;
    logic signed [17:0] u_q;

    logic signed [10:0] e_d;
    logic signed [17:0] e_ext;
    logic signed [15:0] i_shr;
    logic signed [17:0] i_ext;
    logic signed [17:0] u_d;
    logic signed [16:0] integ_sum;
    logic signed [15:0] integ_d;
    logic [7:0]         duty_d;
    logic               windup_hold;
    logic               ch_match;
    logic               unused_mcp_bits;

    // Error is positive when the measured code is above target (too warm).
    assign e_d   = $signed({1'b0, reading_q}) - $signed({1'b0, setpoint});
    assign e_ext = $signed({{7{e_d[10]}}, e_d});
    assign i_shr = integ_q >>> KI_SHIFT;
    assign i_ext = $signed({{2{i_shr[15]}}, i_shr});
    assign u_d   = (e_ext <<< KP_SHIFT) + i_ext;

    assign integ_sum = $signed({integ_q[15], integ_q}) + $signed({{6{e_q[10]}}, e_q});

    always_comb begin
        integ_d = integ_sum[15:0];
        if (integ_sum > LIM_POS) begin
            integ_d = INT_LIM;
        end else if (integ_sum < LIM_NEG) begin
            integ_d = -INT_LIM;
        end
    end

    // Stop integrating while the output is pinned and the error pushes further into the rail.
    assign windup_hold = ((u_q > 18'sd255) && (e_q > 11'sd0)) ||
                         ((u_q < 18'sd0)   && (e_q < 11'sd0));
    assign duty_d      = clamp_duty(u_q);

    assign ch_match        = mcp.mcp_valid && (mcp.mcp_data[MCP_CH_MSB:MCP_CH_LSB] == CHANNEL);
    assign unused_mcp_bits = ^mcp.mcp_data[15:13];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REG_STATE_IDLE;
            period_cnt_q <= 24'd0;
            to_cnt_q     <= 16'd0;
            duty_q       <= 8'd0;
            reading_q    <= 10'd0;
            fault_q      <= 1'b0;
            sample_req_q <= 1'b0;
            integ_q      <= 16'sd0;
            e_q          <= 11'sd0;
            u_q          <= 18'sd0;
        end else begin
            sample_req_q <= 1'b0;
            if (!enable) begin
                // Disable dominates everything, including a same-cycle result word.
                state_q      <= REG_STATE_IDLE;
                period_cnt_q <= 24'd0;
                to_cnt_q     <= 16'd0;
                duty_q       <= 8'd0;
                fault_q      <= 1'b0;
                integ_q      <= 16'sd0;
            end else begin
                case (state_q)
                    REG_STATE_IDLE: begin
                        duty_q       <= 8'd0;
                        integ_q      <= 16'sd0;
                        period_cnt_q <= 24'd0;
                        if (!fault_q) begin
                            state_q <= REG_STATE_WAIT_PERIOD;
                        end
                    end
                    REG_STATE_WAIT_PERIOD: begin
                        if (period_cnt_q == PERIOD - 24'd1) begin
                            period_cnt_q <= 24'd0;
                            state_q      <= REG_STATE_REQUEST;
                        end else begin
                            period_cnt_q <= period_cnt_q + 24'd1;
                        end
                    end
                    REG_STATE_REQUEST: begin
                        if (!mcp.mcp_busy) begin
                            sample_req_q <= 1'b1;
                            to_cnt_q     <= 16'd0;
                            state_q      <= REG_STATE_WAIT_DATA;
                        end
                    end
                    REG_STATE_WAIT_DATA: begin
                        if (ch_match) begin
                            reading_q <= mcp.mcp_data[9:0];
                            state_q   <= REG_STATE_COMPUTE;
                        end else if (to_cnt_q == TIMEOUT) begin
                            fault_q <= 1'b1;
                            duty_q  <= 8'd0;
                            state_q <= REG_STATE_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + 16'd1;
                        end
                    end
                    REG_STATE_COMPUTE: begin
                        e_q     <= e_d;
                        u_q     <= u_d;
                        state_q <= REG_STATE_APPLY;
                    end
                    REG_STATE_APPLY: begin
                        duty_q <= duty_d;
                        if (!windup_hold) begin
                            integ_q <= integ_d;
                        end
                        state_q <= REG_STATE_WAIT_PERIOD;
                    end
                    default: begin
                        state_q <= REG_STATE_IDLE;
                    end
                endcase
            end
        end
    end

    assign mcp.sample_req = sample_req_q;
    assign duty           = duty_q;
    assign reading        = reading_q;
    assign fault          = fault_q;
    assign dbg.state      = state_q;
    assign dbg.integ      = integ_q;

endmodule

// File: tb/tb_peltier_regulator.sv
// Self-checking bench for peltier_regulator: scenario tasks against an arithmetic PI model.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_peltier_regulator;
  import peltier_regulator_pkg::*;

  localparam logic [23:0] P_PERIOD  = 24'd16;
  localparam logic [15:0] P_TIMEOUT = 16'd200;
  localparam int          P_KP      = 2;
  localparam int          P_KI      = 6;
  localparam int          P_LIM     = 4000;
  localparam logic [2:0]  P_CH      = 3'd0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] setpoint = 10'd0;
  logic [7:0] duty;
  logic [9:0] reading;
  logic       fault;
  reg_dbg_t   dbg;

  peltier_regulator_if mcp ();

  int checks = 0;
  int errors = 0;
  int m_integ = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  peltier_regulator #(
    .CHANNEL  (P_CH),
    .PERIOD   (P_PERIOD),
    .TIMEOUT  (P_TIMEOUT),
    .KP_SHIFT (P_KP),
    .KI_SHIFT (P_KI),
    .INT_LIM  (16'sd4000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .setpoint (setpoint),
    .mcp      (mcp.slave),
    .duty     (duty),
    .reading  (reading),
    .fault    (fault),
    .dbg      (dbg)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // PI reference: returns the clamped duty and advances the integrator.
  function automatic int model_step(input int code, input int sp);
    int e, u, d, s;
    e = code - sp;
    u = e * (1 << P_KP) + (m_integ >>> P_KI);
    d = (u < 0) ? 0 : ((u > 255) ? 255 : u);
    if (!((u > 255 && e > 0) || (u < 0 && e < 0))) begin
      s = m_integ + e;
      if (s > P_LIM) s = P_LIM;
      if (s < -P_LIM) s = -P_LIM;
      m_integ = s;
    end
    return d;
  endfunction

  task automatic wait_req(output bit ok, input bit junk);
    ok = 1'b0;
    for (int i = 0; i < int'(P_PERIOD) + 60; i++) begin
      @(negedge clk);
      mcp.mcp_valid = 1'b0;
      if (mcp.sample_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (junk && $urandom_range(0, 3) == 0) begin
        mcp.mcp_data  = {3'b000, P_CH, 10'($urandom_range(0, 1023))};
        mcp.mcp_valid = 1'b1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sample_req_wait: got no pulse, required one within %0d cycles", int'(P_PERIOD) + 60);
    end
  endtask

  task automatic run_sample(input logic [9:0] code, input bit junk, input bit mismatch);
    bit ok;
    logic [7:0] prev;
    logic [7:0] exp_duty;
    wait_req(ok, junk);
    if (!ok) return;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    if (mismatch) begin
      mcp.mcp_data  = {3'b000, 3'(P_CH + 3'd1 + 3'($urandom_range(0, 6))), 10'($urandom_range(0, 1023))};
      mcp.mcp_valid = 1'b1;
      @(negedge clk);
      mcp.mcp_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    prev = duty;
    mcp.mcp_data  = {3'b000, P_CH, code};
    mcp.mcp_valid = 1'b1;
    exp_q.push_back(8'(model_step(int'(code), int'(setpoint))));
    @(negedge clk);
    mcp.mcp_valid = 1'b0;
    checks++;
    if (reading !== code) begin
      errors++;
      $display("FAIL reading_latch: got %0d expected %0d", reading, code);
    end
    @(negedge clk);
    checks++;
    if (duty !== prev) begin
      errors++;
      $display("FAIL duty_early: got %0d expected %0d one cycle after match", duty, prev);
    end
    @(negedge clk);
    exp_duty = exp_q.pop_front();
    checks++;
    if (duty !== exp_duty) begin
      errors++;
      $display("FAIL duty_update: code %0d setpoint %0d got %0d expected %0d", code, setpoint, duty, exp_duty);
    end
    checks++;
    if (dbg.integ !== 16'(m_integ)) begin
      errors++;
      $display("FAIL integ_update: got %0d expected %0d", $signed(dbg.integ), m_integ);
    end
  endtask

  task automatic restart(input logic [9:0] sp);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    setpoint = sp;
    enable = 1'b1;
    m_integ = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mcp.mcp_busy = 1'b0;
    mcp.mcp_valid = 1'b0;
    mcp.mcp_data = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (duty !== 8'd0 || reading !== 10'd0 || fault !== 1'b0 || mcp.sample_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got duty %0d reading %0d fault %0b req %0b, required all 0", duty, reading, fault, mcp.sample_req);
    end
    checks++;
    if (dbg.state !== REG_STATE_IDLE || dbg.integ !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got state %0d integ %0d, required IDLE and 0", dbg.state, dbg.integ);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_request();
    int n;
    n = 0;
    @(negedge clk);
    setpoint = 10'd500;
    enable = 1'b1;
    m_integ = 0;
    // enable is seen at the next rising edge; the pulse lands PERIOD+1 edges after that.
    for (int i = 0; i < int'(P_PERIOD) + 40; i++) begin
      @(negedge clk);
      n++;
      if (mcp.sample_req === 1'b1) break;
    end
    checks++;
    if (n !== int'(P_PERIOD) + 2) begin
      errors++;
      $display("FAIL first_request_latency: got %0d cycles expected %0d", n, int'(P_PERIOD) + 2);
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    restart(10'd500);
    run_sample(10'd520, 1'b0, 1'b0);
    checks++;
    if (duty !== 8'd80 || dbg.integ !== 16'd20) begin
      errors++;
      $display("FAIL vector_520: got duty %0d integ %0d expected 80 and 20", duty, dbg.integ);
    end
    run_sample(10'd600, 1'b0, 1'b0);
    checks++;
    if (duty !== 8'd255 || dbg.integ !== 16'd20) begin
      errors++;
      $display("FAIL vector_600: got duty %0d integ %0d expected 255 and 20", duty, dbg.integ);
    end
    run_sample(10'd400, 1'b0, 1'b0);
    checks++;
    if (duty !== 8'd0 || dbg.integ !== 16'd20) begin
      errors++;
      $display("FAIL vector_400: got duty %0d integ %0d expected 0 and 20", duty, dbg.integ);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    restart(10'd500);
    run_sample(10'd520, 1'b0, 1'b0);
    wait_req(ok, 1'b0);
    checks++;
    if (dbg.state !== REG_STATE_WAIT_DATA) begin
      errors++;
      $display("FAIL pre_reset_state: got %0d expected %0d", dbg.state, REG_STATE_WAIT_DATA);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (duty !== 8'd0 || reading !== 10'd0 || fault !== 1'b0 || mcp.sample_req !== 1'b0 || dbg.state !== REG_STATE_IDLE) begin
      errors++;
      $display("FAIL async_reset: got duty %0d reading %0d fault %0b req %0b state %0d, required 0/IDLE", duty, reading, fault, mcp.sample_req, dbg.state);
    end
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    m_integ = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (mcp.sample_req !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_req: got %0b expected 0 at cycle %0d", mcp.sample_req, i);
      end
    end
  endtask

  task automatic test_busy();
    int pulses;
    pulses = 0;
    @(negedge clk);
    enable = 1'b0;
    mcp.mcp_busy = 1'b1;
    restart(10'd500);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mcp.sample_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || dbg.state !== REG_STATE_REQUEST) begin
      errors++;
      $display("FAIL busy_hold: got %0d pulses state %0d, required 0 pulses in REQUEST", pulses, dbg.state);
    end
    mcp.mcp_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (mcp.sample_req !== 1'b1) begin
      errors++;
      $display("FAIL busy_release: got req %0b expected 1", mcp.sample_req);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mcp.sample_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL busy_single_pulse: got %0d extra pulses expected 0", pulses);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int hit;
    hit = -1;
    restart(10'd500);
    run_sample(10'd520, 1'b0, 1'b0);
    wait_req(ok, 1'b0);
    mcp.mcp_data  = {3'b000, 3'd5, 10'd900};
    mcp.mcp_valid = 1'b1;
    for (int i = 1; i <= int'(P_TIMEOUT) + 20; i++) begin
      @(negedge clk);
      mcp.mcp_valid = 1'b0;
      if (i == int'(P_TIMEOUT) - 2) begin
        checks++;
        if (fault !== 1'b0 || dbg.state !== REG_STATE_WAIT_DATA) begin
          errors++;
          $display("FAIL early_timeout: got fault %0b state %0d, required 0 in WAIT_DATA", fault, dbg.state);
        end
      end
      if (fault === 1'b1) begin
        hit = i;
        break;
      end
    end
    checks++;
    if (hit < 0) begin
      errors++;
      $display("FAIL timeout_fault: got fault %0b expected 1 within %0d cycles", fault, int'(P_TIMEOUT) + 20);
    end
    checks++;
    if (duty !== 8'd0 || reading !== 10'd520) begin
      errors++;
      $display("FAIL timeout_outputs: got duty %0d reading %0d expected 0 and 520", duty, reading);
    end
    repeat (int'(P_PERIOD) + 5) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || dbg.state !== REG_STATE_IDLE) begin
      errors++;
      $display("FAIL fault_sticky: got fault %0b state %0d expected 1 and IDLE", fault, dbg.state);
    end
    restart(10'd500);
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: got %0b expected 0", fault);
    end
    run_sample(10'd530, 1'b0, 1'b0);
  endtask

  task automatic test_enable_drop();
    bit ok;
    logic [9:0] old;
    restart(10'd500);
    run_sample(10'd510, 1'b0, 1'b0);
    old = reading;
    wait_req(ok, 1'b0);
    enable = 1'b0;
    mcp.mcp_data  = {3'b000, P_CH, 10'd777};
    mcp.mcp_valid = 1'b1;
    @(negedge clk);
    mcp.mcp_valid = 1'b0;
    m_integ = 0;
    checks++;
    if (dbg.state !== REG_STATE_IDLE || reading !== old || duty !== 8'd0 || dbg.integ !== 16'd0) begin
      errors++;
      $display("FAIL enable_drop: got state %0d reading %0d duty %0d integ %0d expected IDLE %0d 0 0", dbg.state, reading, duty, dbg.integ, old);
    end
  endtask

  task automatic test_random();
    int c;
    restart(10'($urandom_range(200, 800)));
    for (int k = 0; k < 40; k++) begin
      setpoint = 10'($urandom_range(200, 800));
      if ($urandom_range(0, 3) == 0) c = $urandom_range(0, 1023);
      else c = int'(setpoint) + $urandom_range(0, 160) - 80;
      run_sample(10'(c), 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_saturation();
    int over;
    over = 0;
    restart(10'd500);
    for (int k = 0; k < 210; k++) begin
      run_sample(10'd520, 1'b0, 1'b0);
      if ($signed(dbg.integ) > 16'sd4000) over++;
    end
    checks++;
    if (over !== 0) begin
      errors++;
      $display("FAIL integ_bound: got %0d samples above limit expected 0", over);
    end
    checks++;
    if (dbg.integ !== 16'd4000) begin
      errors++;
      $display("FAIL integ_saturate: got %0d expected 4000", $signed(dbg.integ));
    end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_spec_vectors();
    test_reset_mid_wait();
    test_busy();
    test_timeout();
    test_enable_drop();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
